shift_rot_pipe: RTL

- Parametrised, pipelined successor to the combinational 16-bit left shift/rotate unit.
- Supports left/right shift and rotate at any power-of-two width.
- Optional register after every log2 stage; valid/ready handshake on both sides.
- Sits between the decode/operand stage and the execute result mux; replaces the shifter in the ALU path.

---
 rtl/shift_rot_pipe.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/shift_rot_pipe.sv
// +----------------------------------------------------------------------------+
// | shift_rot_pipe : pipelined log2 left/right shift/rotate, valid/ready flow.  |
// | Optional: SHIFT_ROT_PIPE_SRA_EN makes op 11 an arithmetic right shift.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module shift_rot_pipe #(
  parameter int WIDTH = 16,
  parameter int PIPE  = 1,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [SHW:0]              rdy;
  logic [SHW-1:0]            stg_valid;
  logic [SHW-1:0][WIDTH-1:0] stg_data;
  logic [SHW-2:0][1:0]       mid_op;
  logic [SHW-2:0][SHW-1:0]   mid_shamt;
`ifdef SHIFT_ROT_PIPE_SRA_EN
  logic [SHW-2:0]            mid_sign;
`endif

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x,
                                            input logic [1:0] op,
                                            input logic fill,
                                            input int amt);
    logic [WIDTH-1:0] ones;
    ones = '1;
    case (op)
      2'b00:   step = (x << amt) | (x >> (WIDTH - amt));
      2'b01:   step = x << amt;
      2'b10:   step = (x >> amt) | (x << (WIDTH - amt));
      default: step = (x >> amt) | (fill ? ~(ones >> amt) : '0);
    endcase
  endfunction

  // A stage holding a valid item is ready only if everything downstream moves.
  always_comb begin
    rdy      = '0;
    rdy[SHW] = out_ready;
    for (int k = SHW - 1; k >= 0; k--) begin
      rdy[k] = (((PIPE != 0) || (k == SHW - 1)) && !stg_valid[k]) || rdy[k+1];
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = stg_valid[SHW-1];
  assign out_data  = stg_data[SHW-1];

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int AMT = 1 << k;
    logic             v_in;
    logic [WIDTH-1:0] d_in;
    logic [1:0]       op_in;
    logic [SHW-1:0]   sh_in;
    logic             fill;
    logic             en;
    logic [WIDTH-1:0] d_res;

    if (k == 0) begin : g_first
      assign v_in  = in_valid;
      assign d_in  = in_data;
      assign op_in = in_op;
      assign sh_in = in_shamt;
`ifdef SHIFT_ROT_PIPE_SRA_EN
      assign fill  = in_data[WIDTH-1];
`else
      assign fill  = 1'b0;
`endif
    end else begin : g_next
      assign v_in  = stg_valid[k-1];
      assign d_in  = stg_data[k-1];
      assign op_in = mid_op[k-1];
      assign sh_in = mid_shamt[k-1];
`ifdef SHIFT_ROT_PIPE_SRA_EN
      assign fill  = mid_sign[k-1];
`else
      assign fill  = 1'b0;
`endif
    end

    // The shift amount is consumed LSB-first, so at the last stage only bit 0 can remain set.
    assign en    = (k == SHW - 1) ? (sh_in != '0) : sh_in[0];
    assign d_res = en ? step(d_in, op_in, fill, AMT) : d_in;

    if ((PIPE != 0) || (k == SHW - 1)) begin : g_reg
      logic             v_q;
      logic [WIDTH-1:0] d_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          d_q <= '0;
        end else if (rdy[k]) begin
          v_q <= v_in;
          if (v_in) d_q <= d_res;
        end
      end

      assign stg_valid[k] = v_q;
      assign stg_data[k]  = d_q;

      if (k < SHW - 1) begin : g_side
        logic [1:0]     op_q;
        logic [SHW-1:0] sh_q;
`ifdef SHIFT_ROT_PIPE_SRA_EN
        logic           sg_q;
`endif
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            op_q <= '0;
            sh_q <= '0;
`ifdef SHIFT_ROT_PIPE_SRA_EN
            sg_q <= 1'b0;
`endif
          end else if (rdy[k] && v_in) begin
            op_q <= op_in;
            sh_q <= sh_in >> 1;
`ifdef SHIFT_ROT_PIPE_SRA_EN
            sg_q <= fill;
`endif
          end
        end
        assign mid_op[k]    = op_q;
        assign mid_shamt[k] = sh_q;
`ifdef SHIFT_ROT_PIPE_SRA_EN
        assign mid_sign[k]  = sg_q;
`endif
      end
    end else begin : g_comb
      assign stg_valid[k] = v_in;
      assign stg_data[k]  = d_res;
      assign mid_op[k]    = op_in;
      assign mid_shamt[k] = sh_in >> 1;
`ifdef SHIFT_ROT_PIPE_SRA_EN
      assign mid_sign[k]  = fill;
`endif
    end
  end

endmodule

`default_nettype wire
